round_timer: RTL and testbench

//  Countdown timer for one guessing round; drives the 5-bit progress bar (10..0)
//    to the LED display and the game FSM.

---
 rtl/round_timer_if.sv | 19 +
 rtl/round_timer.sv | 110 +++++++++++
 tb/tb_round_timer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/round_timer_if.sv
// Control/status bundle between the game FSM (master) and the round timer (slave).
interface round_timer_if;
  logic       start;
  logic       pause;
  logic [3:0] difficulty;
  logic [4:0] progress;
  logic       running;
  logic       expired;

  modport master (
    output start, pause, difficulty,
    input  progress, running, expired
  );

  modport slave (
    input  start, pause, difficulty,
    output progress, running, expired
  );
endinterface

// File: rtl/round_timer.sv
// Round countdown timer: progress steps FULL..0 at a difficulty-scaled period,
// with pause/hold, restart and a one-cycle expiry pulse.
module round_timer #(
  parameter int unsigned TICK_N   = 5000000,
  parameter int unsigned FULL     = 10,
  parameter int unsigned DIFF_MAX = 15
) (
  input  logic         clock,
  input  logic         resetn,
  round_timer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [4:0]  FULL_V   = 5'(FULL);
  localparam logic [3:0]  DMAX_V   = 4'(DIFF_MAX);
  localparam logic [31:0] TICK_V   = 32'(TICK_N);
  localparam logic [31:0] DMAX1_V  = 32'(DIFF_MAX) + 32'd1;

  state_t      r_state;
  logic [31:0] r_prescaler;
  logic [31:0] r_period;
  logic [3:0]  r_diff_lat;
  logic [4:0]  r_progress;
  logic        r_running;
  logic        r_expired;

  logic [3:0]  w_diff_eff;
  logic [31:0] w_period_new;
  logic        w_step;

  function automatic logic [3:0] clamp_diff(input logic [3:0] d);
    logic [3:0] res;
    if (d == 4'd0) begin
      res = 4'd1;
    end else if (d > DMAX_V) begin
      res = DMAX_V;
    end else begin
      res = d;
    end
    return res;
  endfunction

  // The multiply result is only captured on start, never used per cycle.
  assign w_diff_eff   = clamp_diff(bus.difficulty);
  assign w_period_new = TICK_V * (DMAX1_V - {28'd0, w_diff_eff});
  assign w_step       = (r_prescaler == (r_period - 32'd1));

  // Timer state machine with registered outputs.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_prescaler <= 32'd0;
      r_period    <= TICK_V * (DMAX1_V - 32'd1);
      r_diff_lat  <= 4'd1;
      r_progress  <= 5'd0;
      r_running   <= 1'b0;
      r_expired   <= 1'b0;
    end else if (bus.start) begin
      r_state     <= S_RUN;
      r_prescaler <= 32'd0;
      r_period    <= w_period_new;
      r_diff_lat  <= w_diff_eff;
      r_progress  <= FULL_V;
      r_running   <= 1'b1;
      r_expired   <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      case (r_state)
        // The resume cycle out of HOLD counts, so the delay equals the paused cycles.
        S_RUN, S_HOLD: begin
          if (bus.pause) begin
            r_state <= S_HOLD;
          end else if (w_step) begin
            r_prescaler <= 32'd0;
            if (r_progress <= 5'd1) begin
              r_progress <= 5'd0;
              r_state    <= S_DONE;
              r_running  <= 1'b0;
              r_expired  <= 1'b1;
            end else begin
              r_progress <= r_progress - 5'd1;
              r_state    <= S_RUN;
            end
          end else begin
            r_prescaler <= r_prescaler + 32'd1;
            r_state     <= S_RUN;
          end
        end
        S_IDLE, S_DONE: begin
          r_running <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign bus.progress = r_progress;
  assign bus.running  = r_running;
  assign bus.expired  = r_expired;

endmodule

// File: tb/tb_round_timer.sv
// Directed bench for round_timer with TICK_N=2, FULL=10, DIFF_MAX=15.
module tb_round_timer;

  typedef struct {
    logic       rst_n;
    logic       start;
    logic       pause;
    logic [3:0] diff;
    logic [4:0] progress;
    logic       running;
    logic       expired;
  } vec_t;

  logic clock;
  logic resetn;
  int   checks;
  int   failures;
  vec_t vecs[20];

  round_timer_if bus_if ();

  round_timer #(.TICK_N(2), .FULL(10), .DIFF_MAX(15)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input logic r, input logic s, input logic p, input logic [3:0] d);
    resetn            = r;
    bus_if.start      = s;
    bus_if.pause      = p;
    bus_if.difficulty = d;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [4:0] ep,
                       input logic er, input logic ee);
    checks++;
    if (bus_if.progress !== ep || bus_if.running !== er || bus_if.expired !== ee) begin
      failures++;
      $display("FAIL %s[%0d]: got progress=%0d running=%0b expired=%0b, want progress=%0d running=%0b expired=%0b",
               name, idx, bus_if.progress, bus_if.running, bus_if.expired, ep, er, ee);
    end
  endtask

  initial begin
    logic [4:0] ep;
    checks            = 0;
    failures          = 0;
    resetn            = 1'b0;
    bus_if.start      = 1'b0;
    bus_if.pause      = 1'b0;
    bus_if.difficulty = 4'd0;

    //            rst   start pause diff   prog   run   exp
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 4'd0,  5'd0,  1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 4'd0,  5'd0,  1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 4'd0,  5'd0,  1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 4'd0,  5'd0,  1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 4'd14, 5'd10, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 4'd14, 5'd10, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 4'd14, 5'd10, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'd14, 5'd10, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 4'd14, 5'd9,  1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'd0,  5'd9,  1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 4'd0,  5'd9,  1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 4'd0,  5'd9,  1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 4'd0,  5'd8,  1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 4'd15, 5'd10, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 4'd15, 5'd10, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 4'd15, 5'd9,  1'b1, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 4'd15, 5'd9,  1'b1, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 4'd15, 5'd8,  1'b1, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 4'd15, 5'd0,  1'b0, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 4'd15, 5'd0,  1'b0, 1'b0};

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].rst_n, vecs[i].start, vecs[i].pause, vecs[i].diff);
      check("table", i, vecs[i].progress, vecs[i].running, vecs[i].expired);
    end

    // Full countdown at P=4, then pause in DONE must do nothing.
    step(1'b1, 1'b1, 1'b0, 4'd14);
    check("basic_start", 0, 5'd10, 1'b1, 1'b0);
    for (int k = 1; k <= 44; k++) begin
      step(1'b1, 1'b0, (k > 41) ? 1'b1 : 1'b0, 4'd14);
      ep = (k < 40) ? 5'(10 - k / 4) : 5'd0;
      check("basic", k, ep, (k < 40) ? 1'b1 : 1'b0, (k == 40) ? 1'b1 : 1'b0);
    end

    // Difficulty 0 clamps to 1 (P=30); mid-run difficulty change is ignored.
    step(1'b1, 1'b1, 1'b0, 4'd0);
    check("clamp_start", 0, 5'd10, 1'b1, 1'b0);
    for (int k = 1; k <= 31; k++) begin
      step(1'b1, 1'b0, 1'b0, (k >= 5) ? 4'd15 : 4'd0);
      check("clamp", k, (k < 30) ? 5'd10 : 5'd9, 1'b1, 1'b0);
    end

    // Pause for 9 cycles once progress reaches 7 at P=4.
    step(1'b1, 1'b1, 1'b0, 4'd14);
    check("pause_start", 0, 5'd10, 1'b1, 1'b0);
    for (int k = 1; k <= 26; k++) begin
      step(1'b1, 1'b0, (k >= 13 && k <= 21) ? 1'b1 : 1'b0, 4'd14);
      if (k < 12)       ep = 5'(10 - k / 4);
      else if (k < 25)  ep = 5'd7;
      else              ep = 5'd6;
      check("pause", k, ep, 1'b1, 1'b0);
    end

    // Restart in the very cycle the 1->0 step would happen (P=2).
    step(1'b1, 1'b1, 1'b0, 4'd15);
    check("collide_start", 0, 5'd10, 1'b1, 1'b0);
    for (int k = 1; k <= 22; k++) begin
      step(1'b1, (k == 20) ? 1'b1 : 1'b0, 1'b0, 4'd15);
      if (k < 20)       ep = 5'(10 - k / 2);
      else if (k < 22)  ep = 5'd10;
      else              ep = 5'd9;
      check("collide", k, ep, 1'b1, 1'b0);
    end

    // Reset while progress=5, then pause alone must stay in IDLE.
    step(1'b1, 1'b1, 1'b0, 4'd15);
    for (int k = 1; k <= 10; k++) step(1'b1, 1'b0, 1'b0, 4'd15);
    check("midrun_pre", 0, 5'd5, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'd15);
    check("midrun_rst", 0, 5'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 1'b0, 1'b1, 4'd15);
      check("idle_pause", k, 5'd0, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
